cellrv32_cpu_cp_fpu_f2i_gen: RTL and testbench
==============================================

CELLRV32_CPU_CP_FPU_F2I_GEN -- requirements
Module: cellrv32_cpu_cp_fpu_f2i_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, integer result width, legal values 32 or 64.
REQ-002 SHALL have parameter EXP_W, default 8, float exponent width (8 single, 11 double).
REQ-003 SHALL have parameter MANT_W, default 23, stored mantissa width (23 single, 52 double).
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit: operation trigger, sampled only in IDLE.
REQ-007 SHALL have port rmode_i, input, 3 bits: RISC-V rounding mode.
REQ-008 SHALL have port funct_i, input, 1 bit: 0 = signed, 1 = unsigned conversion.
REQ-009 SHALL have port sign_i, input, 1 bit: operand sign.
REQ-010 SHALL have port exponent_i, input, EXP_W bits: biased exponent.
REQ-011 SHALL have port mantissa_i, input, MANT_W bits: stored mantissa.
REQ-012 SHALL have port class_i, input, 10 bits: operand class, indexed by fp_class_*_c.
REQ-013 SHALL have port busy_o, output, 1 bit: high in every non-IDLE state.
REQ-014 SHALL have port result_o, output, XLEN bits: integer result, held until the next done_o.
REQ-015 SHALL have port flags_o, output, 5 bits: exception flags, indexed by fp_exc_*_c, held with result_o.
REQ-016 SHALL have port done_o, output, 1 bit: single-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, PREPARE, NORMALIZE, ROUND, FINALIZE: IDLE->PREPARE on start_i; PREPARE->FINALIZE for special or overflow operands, else ->NORMALIZE; NORMALIZE->ROUND when the shift count reaches 0; ROUND->FINALIZE; FINALIZE->IDLE.
REQ-018 SHALL ignore start_i in any state except IDLE; inputs other than funct_i/rmode_i SHALL be captured on the start edge.
REQ-019 SHALL define E = exponent - (2^(EXP_W-1)-1); for 0 <= E < XLEN, NORMALIZE SHALL shift one mantissa bit per cycle into the integer register for k = E cycles, plus one terminal cycle.
REQ-020 SHALL raise done_o exactly 5+k cycles after the sampling edge for normal paths, and 3 cycles after for NaN, inf, zero or E >= XLEN.
REQ-021 SHALL form guard as the next mantissa bit, round as the one after, and sticky as OR of all remaining bits; for E = -1, integer = 0, guard = 1, sticky = OR(mantissa); for E < -1 or subnormal, integer = 0, guard = 0, sticky = 1.
REQ-022 SHALL round the magnitude with increment = RNE: g&(r|s|lsb); RTZ: 0; RDN: (g|r|s)&sign; RUP: (g|r|s)&~sign; RMM (100, see REQ-031): g; rmode 101-111 SHALL behave as RNE.
REQ-023 SHALL treat as overflow: E >= XLEN, or carry out of bit XLEN-1 after rounding; signed mode additionally magnitude > 2^(XLEN-1)-1 when positive or > 2^(XLEN-1) when negative.
REQ-024 Signed saturation: NaN, +inf or positive overflow SHALL yield 2^(XLEN-1)-1; -inf or negative overflow SHALL yield -2^(XLEN-1); otherwise the result SHALL be the two's-complement negation when sign = 1.
REQ-025 Unsigned saturation: NaN, +inf or positive overflow SHALL yield all ones; -inf, or negative with nonzero rounded magnitude, SHALL yield 0; negative with zero rounded magnitude SHALL yield 0 without NV.
REQ-026 SHALL set NV for every saturated/invalid case in REQ-024/025 and NX when g|r|s and the result is not invalid; OF, UF and DZ SHALL always be 0; zero operands SHALL give result 0 with no flags.
REQ-027 SHALL update result_o and flags_o in FINALIZE together with the done_o pulse.

Reset
REQ-028 rst_i SHALL force IDLE, result_o = 0, flags_o = 0, done_o = 0 and busy_o = 0 immediately, without waiting for a clock edge.
REQ-029 rst_i asserted mid-operation SHALL abort the operation with no done_o pulse; the first start_i after release SHALL be accepted normally.

Configuration
REQ-030 SHALL use macro CELLRV32_FPU_F2I_RMM_EN.
REQ-031 With CELLRV32_FPU_F2I_RMM_EN defined, rmode 100 SHALL round ties away from zero; without it, rmode 100 SHALL behave exactly as RNE.

Verification
REQ-032 2.5 (exp 128, mant 0x200000), RNE, signed -> result 2, NX = 1, done_o 6 cycles after start.
REQ-033 -2.5, RDN, signed -> 0xFFFFFFFD, NX; the same operand with RUP -> 0xFFFFFFFE, NX.
REQ-034 +2^31 (exp 158): signed -> 0x7FFFFFFF with NV; unsigned -> 0x80000000, no flags; -2^31 signed -> 0x80000000, no flags.
REQ-035 qNaN -> 0x7FFFFFFF with NV, done_o 3 cycles after start; -1.0 unsigned -> 0 with NV; -0.3 unsigned RTZ -> 0 with NX only.
REQ-036 0.5 (exp 126), rmode 100 -> 1, NX with macro; 0, NX without macro.
REQ-037 rst_i pulsed during NORMALIZE -> outputs 0 immediately, no done_o pulse; the next start with 7.0 -> 7, no flags.

Source files
------------

// File: rtl/cellrv32_cpu_cp_fpu_f2i_gen.sv
// Multi-cycle float-to-integer converter. Converts a sign/exponent/mantissa operand to a signed or unsigned XLEN integer.
// Optional feature: define CELLRV32_FPU_F2I_RMM_EN to make rmode 100 round ties away from zero (otherwise it rounds like RNE).
module cellrv32_cpu_cp_fpu_f2i_gen #(
    parameter int XLEN   = 32,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        rmode_i,
    input  logic              funct_i,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exponent_i,
    input  logic [MANT_W-1:0] mantissa_i,
    input  logic [9:0]        class_i,
    output logic              busy_o,
    output logic [XLEN-1:0]   result_o,
    output logic [4:0]        flags_o,
    output logic              done_o
);

    localparam int FP_CLASS_NEG_INF_C    = 0;
    localparam int FP_CLASS_NEG_NORM_C   = 1;
    localparam int FP_CLASS_NEG_DENORM_C = 2;
    localparam int FP_CLASS_NEG_ZERO_C   = 3;
    localparam int FP_CLASS_POS_ZERO_C   = 4;
    localparam int FP_CLASS_POS_DENORM_C = 5;
    localparam int FP_CLASS_POS_NORM_C   = 6;
    localparam int FP_CLASS_POS_INF_C    = 7;
    localparam int FP_CLASS_SNAN_C       = 8;
    localparam int FP_CLASS_QNAN_C       = 9;

    localparam int FP_EXC_NX_C = 0;
    localparam int FP_EXC_NV_C = 4;

    localparam int CNT_W = $clog2(XLEN);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EXP_W+1:0] BIAS_S = $signed((EXP_W + 2)'(BIAS));
    localparam logic signed [EXP_W+1:0] XLEN_S = $signed((EXP_W + 2)'(XLEN));
    localparam logic [XLEN-1:0] MAX_POS = {1'b0, {(XLEN - 1){1'b1}}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    state_t state;

    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0] mant_r;
    logic              nan_r;
    logic              inf_r;
    logic              zero_r;
    logic              denorm_r;
    logic              norm_r;
    logic              big_r;
    logic [XLEN-1:0]   int_r;
    logic [MANT_W-1:0] frac_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN:0]     mag_r;
    logic              inexact_r;

    logic signed [EXP_W+1:0] unbiased;
    logic                    e_neg;
    logic                    e_minus1;
    logic                    e_big;
    logic                    special;

    logic guard_bit;
    logic round_bit;
    logic sticky_bit;
    logic inc;

    logic            carry;
    logic [XLEN-1:0] mag_lo;
    logic            sgn_ovf;
    logic [XLEN-1:0] fin_result;
    logic            fin_nv;
    logic            fin_nx;

    assign busy_o = (state != S_IDLE);

    // Operand classification, evaluated on the registered operand during PREPARE
    always_comb begin
        unbiased = $signed({2'b00, exp_r}) - BIAS_S;
        e_neg    = unbiased[EXP_W+1];
        e_minus1 = (unbiased == {(EXP_W + 2){1'b1}});
        e_big    = norm_r && !e_neg && (unbiased >= XLEN_S);
        special  = nan_r || inf_r || zero_r || e_big;
    end

    assign guard_bit  = frac_r[MANT_W-1];
    assign round_bit  = frac_r[MANT_W-2];
    assign sticky_bit = |frac_r[MANT_W-3:0];

    // rmode and funct are used live, they are not captured at start
    always_comb begin
        inc = 1'b0;
        case (rmode_i)
            3'b001: inc = 1'b0;
            3'b010: inc = (guard_bit | round_bit | sticky_bit) & sign_r;
            3'b011: inc = (guard_bit | round_bit | sticky_bit) & ~sign_r;
`ifdef CELLRV32_FPU_F2I_RMM_EN
            3'b100: inc = guard_bit;
`endif
            default: inc = guard_bit & (round_bit | sticky_bit | int_r[0]);
        endcase
    end

    always_comb begin
        carry      = mag_r[XLEN];
        mag_lo     = mag_r[XLEN-1:0];
        sgn_ovf    = carry | (sign_r ? (mag_lo > MIN_NEG) : (mag_lo > MAX_POS));
        fin_result = '0;
        fin_nv     = 1'b0;
        fin_nx     = 1'b0;
        if (zero_r) begin
            fin_result = '0;
        end else if (!funct_i) begin
            if (nan_r) begin
                fin_result = MAX_POS;
                fin_nv     = 1'b1;
            end else if (inf_r || big_r || sgn_ovf) begin
                fin_result = sign_r ? MIN_NEG : MAX_POS;
                fin_nv     = 1'b1;
            end else begin
                fin_result = sign_r ? (XLEN'(0) - mag_lo) : mag_lo;
                fin_nx     = inexact_r;
            end
        end else begin
            if (nan_r) begin
                fin_result = '1;
                fin_nv     = 1'b1;
            end else if (sign_r) begin
                fin_result = '0;
                if (inf_r || big_r || carry || (mag_lo != '0)) begin
                    fin_nv = 1'b1;
                end else begin
                    fin_nx = inexact_r;
                end
            end else if (inf_r || big_r || carry) begin
                fin_result = '1;
                fin_nv     = 1'b1;
            end else begin
                fin_result = mag_lo;
                fin_nx     = inexact_r;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            nan_r     <= 1'b0;
            inf_r     <= 1'b0;
            zero_r    <= 1'b0;
            denorm_r  <= 1'b0;
            norm_r    <= 1'b0;
            big_r     <= 1'b0;
            int_r     <= '0;
            frac_r    <= '0;
            cnt_r     <= '0;
            mag_r     <= '0;
            inexact_r <= 1'b0;
            result_o  <= '0;
            flags_o   <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        sign_r   <= sign_i;
                        exp_r    <= exponent_i;
                        mant_r   <= mantissa_i;
                        nan_r    <= class_i[FP_CLASS_SNAN_C] | class_i[FP_CLASS_QNAN_C];
                        inf_r    <= class_i[FP_CLASS_NEG_INF_C] | class_i[FP_CLASS_POS_INF_C];
                        zero_r   <= class_i[FP_CLASS_NEG_ZERO_C] | class_i[FP_CLASS_POS_ZERO_C];
                        denorm_r <= class_i[FP_CLASS_NEG_DENORM_C] | class_i[FP_CLASS_POS_DENORM_C];
                        norm_r   <= class_i[FP_CLASS_NEG_NORM_C] | class_i[FP_CLASS_POS_NORM_C];
                        state    <= S_PREPARE;
                    end
                end
                S_PREPARE: begin
                    big_r     <= e_big;
                    mag_r     <= '0;
                    inexact_r <= 1'b0;
                    // Tiny operands park their guard/round/sticky pattern directly in frac_r
                    if (denorm_r || (e_neg && !e_minus1)) begin
                        int_r  <= '0;
                        frac_r <= {2'b00, 1'b1, {(MANT_W - 3){1'b0}}};
                        cnt_r  <= '0;
                    end else if (e_minus1) begin
                        int_r  <= '0;
                        frac_r <= {1'b1, 1'b0, |mant_r, {(MANT_W - 3){1'b0}}};
                        cnt_r  <= '0;
                    end else begin
                        int_r  <= XLEN'(1);
                        frac_r <= mant_r;
                        cnt_r  <= special ? '0 : unbiased[CNT_W-1:0];
                    end
                    state <= special ? S_FINALIZE : S_NORMALIZE;
                end
                S_NORMALIZE: begin
                    if (cnt_r != '0) begin
                        int_r  <= {int_r[XLEN-2:0], frac_r[MANT_W-1]};
                        frac_r <= {frac_r[MANT_W-2:0], 1'b0};
                        cnt_r  <= cnt_r - CNT_W'(1);
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    mag_r     <= {1'b0, int_r} + (XLEN + 1)'(inc);
                    inexact_r <= guard_bit | round_bit | sticky_bit;
                    state     <= S_FINALIZE;
                end
                S_FINALIZE: begin
                    result_o              <= fin_result;
                    flags_o               <= 5'b00000;
                    flags_o[FP_EXC_NV_C]  <= fin_nv;
                    flags_o[FP_EXC_NX_C]  <= fin_nx;
                    done_o                <= 1'b1;
                    state                 <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_f2i_gen.sv
// Directed self-checking bench for cellrv32_cpu_cp_fpu_f2i_gen (single precision, XLEN 32).
// Expected values for rmode 100 depend on CELLRV32_FPU_F2I_RMM_EN.
module tb_cellrv32_cpu_cp_fpu_f2i_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  rmode_i = 3'b000;
    logic        funct_i = 1'b0;
    logic        sign_i = 1'b0;
    logic [7:0]  exponent_i = '0;
    logic [22:0] mantissa_i = '0;
    logic [9:0]  class_i = '0;
    logic        busy_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        done_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        bit          s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [9:0]  c;
        logic [2:0]  rm;
        bit          f;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    cellrv32_cpu_cp_fpu_f2i_gen dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .rmode_i    (rmode_i),
        .funct_i    (funct_i),
        .sign_i     (sign_i),
        .exponent_i (exponent_i),
        .mantissa_i (mantissa_i),
        .class_i    (class_i),
        .busy_o     (busy_o),
        .result_o   (result_o),
        .flags_o    (flags_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Starts one conversion and counts negedges until done_o; lat = -1 on timeout
    task automatic do_convert(input vec_t v, output logic [31:0] res, output logic [4:0] flg,
                              output int lat, output logic busy_seen);
        @(negedge clk_i);
        sign_i = v.s; exponent_i = v.e; mantissa_i = v.m; class_i = v.c;
        rmode_i = v.rm; funct_i = v.f; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        busy_seen = busy_o;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            if (done_o) begin
                lat = i;
                break;
            end
            @(negedge clk_i);
        end
        res = result_o;
        flg = flags_o;
    endtask

    task automatic run_table(input vec_t tbl[$]);
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        logic        busy_seen;
        foreach (tbl[i]) begin
            do_convert(tbl[i], res, flg, lat, busy_seen);
            vectors++;
            if (res !== tbl[i].res) begin
                miscompares++;
                $display("[TB] FAIL %s result: got %h expected %h", tbl[i].name, res, tbl[i].res);
            end
            vectors++;
            if (flg !== tbl[i].flg) begin
                miscompares++;
                $display("[TB] FAIL %s flags: got %b expected %b", tbl[i].name, flg, tbl[i].flg);
            end
            vectors++;
            if (lat != tbl[i].lat) begin
                miscompares++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].lat);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        vectors++;
        if (result_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset result: got %h expected 00000000", result_o);
        end
        vectors++;
        if (flags_o !== 5'h00) begin
            miscompares++;
            $display("[TB] FAIL reset flags: got %b expected 00000", flags_o);
        end
        vectors++;
        if ({busy_o, done_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset busy/done: got %b expected 00", {busy_o, done_o});
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_rounding();
        vec_t        tbl[$];
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        logic        busy_seen;
        tbl.push_back('{"pos2p5_rne", 1'b0, 8'd128, 23'h200000, 10'h040, 3'b000, 1'b0, 32'h00000002, 5'h01, 6});
        tbl.push_back('{"neg2p5_rdn", 1'b1, 8'd128, 23'h200000, 10'h002, 3'b010, 1'b0, 32'hFFFFFFFD, 5'h01, 6});
        tbl.push_back('{"neg2p5_rup", 1'b1, 8'd128, 23'h200000, 10'h002, 3'b011, 1'b0, 32'hFFFFFFFE, 5'h01, 6});
        tbl.push_back('{"pos3p5_rne", 1'b0, 8'd128, 23'h600000, 10'h040, 3'b000, 1'b0, 32'h00000004, 5'h01, 6});
        tbl.push_back('{"pos2p5_rtz", 1'b0, 8'd128, 23'h200000, 10'h040, 3'b001, 1'b0, 32'h00000002, 5'h01, 6});
        tbl.push_back('{"pos0p75_rne", 1'b0, 8'd126, 23'h400000, 10'h040, 3'b000, 1'b0, 32'h00000001, 5'h01, 5});
        tbl.push_back('{"denorm_rup", 1'b0, 8'd0, 23'h000001, 10'h020, 3'b011, 1'b0, 32'h00000001, 5'h01, 5});
        run_table(tbl);
        do_convert('{"pos1_exact", 1'b0, 8'd127, 23'h0, 10'h040, 3'b000, 1'b0, 32'h1, 5'h0, 5},
                   res, flg, lat, busy_seen);
        vectors++;
        if (busy_seen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_during_op: got %b expected 1", busy_seen);
        end
        vectors++;
        if ({res, flg} !== {32'h1, 5'h0}) begin
            miscompares++;
            $display("[TB] FAIL pos1_exact: got %h/%b expected 00000001/00000", res, flg);
        end
        @(negedge clk_i);
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_pulse_width: got %b expected 0", done_o);
        end
    endtask

    task automatic test_saturation();
        vec_t tbl[$];
        tbl.push_back('{"pos2e31_signed", 1'b0, 8'd158, 23'h0, 10'h040, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 36});
        tbl.push_back('{"pos2e31_unsigned", 1'b0, 8'd158, 23'h0, 10'h040, 3'b000, 1'b1, 32'h80000000, 5'h00, 36});
        tbl.push_back('{"neg2e31_signed", 1'b1, 8'd158, 23'h0, 10'h002, 3'b000, 1'b0, 32'h80000000, 5'h00, 36});
        tbl.push_back('{"pos1e10_signed", 1'b0, 8'd160, 23'h150000, 10'h040, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 3});
        tbl.push_back('{"neg1e10_unsigned", 1'b1, 8'd160, 23'h150000, 10'h002, 3'b000, 1'b1, 32'h00000000, 5'h10, 3});
        run_table(tbl);
    endtask

    task automatic test_special();
        vec_t tbl[$];
        tbl.push_back('{"qnan_signed", 1'b0, 8'd255, 23'h400000, 10'h200, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 3});
        tbl.push_back('{"qnan_unsigned", 1'b0, 8'd255, 23'h400000, 10'h200, 3'b000, 1'b1, 32'hFFFFFFFF, 5'h10, 3});
        tbl.push_back('{"pos_inf_signed", 1'b0, 8'd255, 23'h0, 10'h080, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 3});
        tbl.push_back('{"neg_inf_signed", 1'b1, 8'd255, 23'h0, 10'h001, 3'b000, 1'b0, 32'h80000000, 5'h10, 3});
        tbl.push_back('{"pos_zero", 1'b0, 8'd0, 23'h0, 10'h010, 3'b011, 1'b0, 32'h00000000, 5'h00, 3});
        tbl.push_back('{"neg1_unsigned", 1'b1, 8'd127, 23'h0, 10'h002, 3'b000, 1'b1, 32'h00000000, 5'h10, 5});
        tbl.push_back('{"neg0p3_unsigned_rtz", 1'b1, 8'd125, 23'h19999A, 10'h002, 3'b001, 1'b1, 32'h00000000, 5'h01, 5});
        run_table(tbl);
    endtask

    task automatic test_rmm();
        vec_t tbl[$];
`ifdef CELLRV32_FPU_F2I_RMM_EN
        tbl.push_back('{"half_rmm", 1'b0, 8'd126, 23'h0, 10'h040, 3'b100, 1'b0, 32'h00000001, 5'h01, 5});
        tbl.push_back('{"neg2p5_rmm", 1'b1, 8'd128, 23'h200000, 10'h002, 3'b100, 1'b0, 32'hFFFFFFFD, 5'h01, 6});
`else
        tbl.push_back('{"half_rmm", 1'b0, 8'd126, 23'h0, 10'h040, 3'b100, 1'b0, 32'h00000000, 5'h01, 5});
        tbl.push_back('{"neg2p5_rmm", 1'b1, 8'd128, 23'h200000, 10'h002, 3'b100, 1'b0, 32'hFFFFFFFE, 5'h01, 6});
`endif
        run_table(tbl);
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = -1;
        @(negedge clk_i);
        sign_i = 1'b0; exponent_i = 8'd128; mantissa_i = 23'h200000; class_i = 10'h040;
        rmode_i = 3'b000; funct_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        exponent_i = 8'd129; mantissa_i = 23'h600000;
        for (int i = 1; i <= 50; i++) begin
            if (i == 4) start_i = 1'b0;
            if (done_o) begin
                lat = i;
                break;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        vectors++;
        if (lat != 6) begin
            miscompares++;
            $display("[TB] FAIL start_while_busy latency: got %0d expected 6", lat);
        end
        vectors++;
        if ({result_o, flags_o} !== {32'h2, 5'h01}) begin
            miscompares++;
            $display("[TB] FAIL start_while_busy: got %h/%b expected 00000002/00001", result_o, flags_o);
        end
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_reset_abort();
        vec_t        v;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        logic        busy_seen;
        int          pulses;
        @(negedge clk_i);
        sign_i = 1'b0; exponent_i = 8'd158; mantissa_i = 23'h0; class_i = 10'h040;
        rmode_i = 3'b000; funct_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({result_o, flags_o, busy_o, done_o} !== 39'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_async_clear: got %h/%b/%b/%b expected all zero",
                     result_o, flags_o, busy_o, done_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        v = '{"seven_after_abort", 1'b0, 8'd129, 23'h600000, 10'h040, 3'b000, 1'b0, 32'h7, 5'h0, 7};
        do_convert(v, res, flg, lat, busy_seen);
        vectors++;
        if ({res, flg} !== {32'h7, 5'h0}) begin
            miscompares++;
            $display("[TB] FAIL seven_after_abort: got %h/%b expected 00000007/00000", res, flg);
        end
        vectors++;
        if (lat != 7) begin
            miscompares++;
            $display("[TB] FAIL seven_after_abort latency: got %0d expected 7", lat);
        end
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_rounding();
        test_saturation();
        test_special();
        test_rmm();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
